div_unit: RTL and testbench

//   Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   It is the multi-cycle inverse-arithmetic companion to the single-cycle ALU.
//   The EX stage issues operands with a start/ready handshake, stalls while o_busy is high,
//   and captures o_result on the o_valid pulse.

---
 rtl/div_unit.sv | 183 ++++++++++++++++++
 tb/tb_div_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//   Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   Operands are taken on a start/ready handshake, the quotient is developed
//   one bit per cycle (MSB first) on magnitudes, and the signs are restored
//   in a single fix-up cycle. Divide-by-zero and signed overflow bypass the
//   iteration and finish one cycle after accept.
//
//   State table
//     state | meaning
//     IDLE  | ready for a new request
//     CALC  | one restoring-division step per cycle, XLEN steps
//     FIX   | sign correction, load o_result
//     DONE  | o_valid pulse, return to IDLE
//
// Ports
//   i_clk     clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_start   request valid, accepted only while o_ready=1
//   o_ready   idle, can accept a request
//   i_op      2'b00 DIV, 2'b01 DIVU, 2'b10 REM, 2'b11 REMU
//   i_a       dividend, sampled on accept
//   i_b       divisor, sampled on accept
//   i_kill    flush: abort the current operation, no result
//   o_busy    operation in flight
//   o_valid   one-cycle pulse, o_result holds the answer
//   o_result  quotient or remainder, held until overwritten by a later result
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_kill,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] ONE     = XLEN'(1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] b_mag;
  logic            a_neg;
  logic            b_neg;
  logic            want_rem;

  // Accept-time operand conditioning. Sign flags are only ever set for the
  // signed ops, so the fix-up stage needs no separate signed/unsigned flag.
  logic            in_signed;
  logic            in_a_neg;
  logic            in_b_neg;
  logic [XLEN-1:0] in_a_mag;
  logic [XLEN-1:0] in_b_mag;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] special_result;

  always_comb begin
    in_signed = ~i_op[0];
    in_a_neg  = in_signed & i_a[XLEN-1];
    in_b_neg  = in_signed & i_b[XLEN-1];
    in_a_mag  = in_a_neg ? (~i_a + ONE) : i_a;
    in_b_mag  = in_b_neg ? (~i_b + ONE) : i_b;
    div_zero  = (i_b == '0);
    overflow  = in_signed && (i_a == MIN_NEG) && (i_b == '1);
    special_result = '0;
    if (div_zero) begin
      special_result = i_op[1] ? i_a : '1;
    end else if (overflow) begin
      special_result = i_op[1] ? '0 : i_a;
    end
  end

  // One restoring step: shift the next dividend bit into the partial
  // remainder and keep the subtraction only if it did not borrow.
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;
  logic            fits;

  always_comb begin
    rem_shift = {rem, quo[XLEN-1]};
    diff      = rem_shift - {1'b0, b_mag};
    fits      = ~diff[XLEN];
  end

  logic [XLEN-1:0] quo_fixed;
  logic [XLEN-1:0] rem_fixed;

  always_comb begin
    quo_fixed = (a_neg ^ b_neg) ? (~quo + ONE) : quo;
    rem_fixed = a_neg ? (~rem + ONE) : rem;
  end

  // o_ready/o_busy follow the state directly so they switch as soon as the
  // asynchronous reset forces IDLE.
  assign o_ready = (state == IDLE);
  assign o_busy  = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      count    <= '0;
      quo      <= '0;
      rem      <= '0;
      b_mag    <= '0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      want_rem <= 1'b0;
      o_valid  <= 1'b0;
      o_result <= '0;
    end else if (i_kill) begin
      // Flush beats everything, including a simultaneous start in IDLE.
      // A pulse already on o_valid in DONE has been seen; it just ends here.
      state   <= IDLE;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            want_rem <= i_op[1];
            a_neg    <= in_a_neg;
            b_neg    <= in_b_neg;
            b_mag    <= in_b_mag;
            quo      <= in_a_mag;
            rem      <= '0;
            count    <= '0;
            if (div_zero || overflow) begin
              o_result <= special_result;
              o_valid  <= 1'b1;
              state    <= DONE;
            end else begin
              state    <= CALC;
            end
          end
        end

        CALC: begin
          rem   <= fits ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
          quo   <= {quo[XLEN-2:0], fits};
          count <= count + 1'b1;
          if (count == LAST) begin
            state <= FIX;
          end
        end

        FIX: begin
          o_result <= want_rem ? rem_fixed : quo_fixed;
          o_valid  <= 1'b1;
          state    <= DONE;
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [1:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_kill;
  logic        o_ready;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_result;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  div_unit #(.XLEN(32)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (i_start),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .i_kill   (i_kill),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_result (o_result)
  );

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  // Issues one request and follows it to the result. lat counts cycles
  // after the accept edge (sampled on negedges). With poke set, extra start
  // pulses with different operands are driven while the unit is busy.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit poke,
                       input string name);
    int n;
    bit busy_ok;
    @(negedge clk);
    check({name, " ready"}, 32'(o_ready), 32'd1);
    i_start = 1'b1; i_op = op; i_a = a; i_b = b;
    @(negedge clk);
    i_start = 1'b0;
    n = 1;
    busy_ok = 1'b1;
    while (!o_valid && n < 60) begin
      if (!o_busy || o_ready) busy_ok = 1'b0;
      if (poke) begin
        i_start = (n == 5 || n == 20);
        i_op = OP_DIVU; i_a = 32'd1000; i_b = 32'd1;
      end
      @(negedge clk);
      n++;
    end
    i_start = 1'b0;
    if (!o_busy) busy_ok = 1'b0;
    check({name, " latency"}, 32'(n), 32'(lat));
    check({name, " result"}, o_result, exp);
    check({name, " busy"}, 32'(busy_ok), 32'd1);
    @(negedge clk);
    check({name, " pulse_len"}, 32'(o_valid), 32'd0);
  endtask

  // Starts a long op and flushes it in cycle kill_n after accept.
  task automatic do_kill(input int kill_n, input string name);
    logic [31:0] held;
    bit seen;
    held = o_result;
    @(negedge clk);
    i_start = 1'b1; i_op = OP_DIVU; i_a = 32'hFFFF_FFFF; i_b = 32'd3;
    @(negedge clk);
    i_start = 1'b0;
    for (int n = 1; n < kill_n; n++) @(negedge clk);
    i_kill = 1'b1;
    @(negedge clk);
    i_kill = 1'b0;
    check({name, " ready"}, 32'(o_ready), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (o_valid) seen = 1'b1;
      @(negedge clk);
    end
    check({name, " no_valid"}, 32'(seen), 32'd0);
    check({name, " result_held"}, o_result, held);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; i_start = 1'b0; i_op = 2'b00; i_a = '0; i_b = '0; i_kill = 1'b0;

    vecs.push_back('{OP_DIVU, 32'd100,        32'd7,          32'd14,         34, "divu_100_7"});
    vecs.push_back('{OP_REMU, 32'd100,        32'd7,          32'd2,          34, "remu_100_7"});
    vecs.push_back('{OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34, "div_m7_2"});
    vecs.push_back('{OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34, "rem_m7_2"});
    vecs.push_back('{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34, "rem_7_m2"});
    vecs.push_back('{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34, "div_7_m2"});
    vecs.push_back('{OP_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          34, "div_m7_m2"});
    vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF,  32'd3,          32'h5555_5555,  34, "divu_max_3"});
    vecs.push_back('{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34, "divu_max_1"});
    vecs.push_back('{OP_DIV,  32'd0,          32'd5,          32'd0,          34, "div_0_5"});
    vecs.push_back('{OP_DIV,  32'h8000_0000,  32'd1,          32'h8000_0000,  34, "div_min_1"});
    vecs.push_back('{OP_DIV,  32'h8000_0000,  32'd3,          32'hD555_5556,  34, "div_min_3"});
    vecs.push_back('{OP_REM,  32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  34, "rem_min_3"});
    vecs.push_back('{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  "divu_5_0"});
    vecs.push_back('{OP_REMU, 32'd5,          32'd0,          32'd5,          1,  "remu_5_0"});
    vecs.push_back('{OP_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  1,  "div_m5_0"});
    vecs.push_back('{OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1,  "rem_m5_0"});
    vecs.push_back('{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  "div_ovf"});
    vecs.push_back('{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  "rem_ovf"});
    vecs.push_back('{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34, "divu_no_ovf"});

    repeat (3) @(negedge clk);
    check("reset ready",  32'(o_ready),  32'd1);
    check("reset busy",   32'(o_busy),   32'd0);
    check("reset valid",  32'(o_valid),  32'd0);
    check("reset result", o_result,      32'd0);
    rst_n = 1'b1;

    foreach (vecs[i])
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b0, vecs[i].name);

    // Start pulses while busy must not disturb the operation in flight.
    do_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b1, "busy_ignore");

    do_kill(10, "kill_calc");
    do_op(OP_REMU, 32'hFFFF_FFFF, 32'd10, 32'd5, 34, 1'b0, "after_kill");
    do_kill(33, "kill_fix");

    // Start together with kill in IDLE: not accepted.
    @(negedge clk);
    i_start = 1'b1; i_kill = 1'b1; i_op = OP_DIVU; i_a = 32'd9; i_b = 32'd0;
    @(negedge clk);
    i_start = 1'b0; i_kill = 1'b0;
    check("start_kill ready", 32'(o_ready), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (o_valid || o_busy) seen = 1'b1;
      @(negedge clk);
    end
    check("start_kill idle", 32'(seen), 32'd0);
    check("start_kill result", o_result, 32'd5);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    i_start = 1'b1; i_op = OP_DIVU; i_a = 32'hFFFF_FFFF; i_b = 32'd3;
    @(negedge clk);
    i_start = 1'b0;
    for (int n = 1; n < 20; n++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid valid",  32'(o_valid), 32'd0);
    check("rst_mid result", o_result,     32'd0);
    check("rst_mid ready",  32'(o_ready), 32'd1);
    check("rst_mid busy",   32'(o_busy),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (o_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("rst_mid no_valid", 32'(seen), 32'd0);
    check("rst_mid result_after", o_result, 32'd0);

    // Random sweep against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      int          lat;
      int          sel;
      op  = 2'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        3: b = 32'd0 - 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      lat = ((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34;
      do_op(op, a, b, ref_div(op, a, b), lat, 1'b0, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
